// File: rtl/packet_tx.sv
// Serial packet transmitter: 4-bit address MSB first, pad ones, then payload bytes LSB first,
// framed by active-low frame_n_out/valid_n_out toward a router input port.
module packet_tx #(
  parameter int PAD_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] dest_addr,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       din_out,
  output logic       frame_n_out,
  output logic       valid_n_out,
  output logic       busy_out,
  output logic       done_out
);

  if (PAD_CYCLES < 1 || PAD_CYCLES > 15) begin : g_bad_pad
    $error("packet_tx: PAD_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    PAD  = 3'd2,
    WAIT = 3'd3,
    DATA = 3'd4
  } state_t;

  localparam logic [3:0] PAD_LAST = 4'(PAD_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] addr_reg, addr_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [3:0] pad_cnt, pad_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       last_reg, last_next;
  logic       done_next;

  // All line outputs decode registered state only, so nothing on the host side
  // can ripple combinationally onto din_out/frame_n_out/valid_n_out.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    state_next   = state;
    addr_next    = addr_reg;
    bit_cnt_next = bit_cnt;
    pad_cnt_next = pad_cnt;
    shift_next   = shift_reg;
    last_next    = last_reg;
    done_next    = 1'b0;
    din_out      = 1'b0;
    frame_n_out  = 1'b1;
    valid_n_out  = 1'b1;
    byte_ready   = 1'b0;
    busy_out     = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (start) begin
          addr_next    = dest_addr;
          bit_cnt_next = 3'd0;
          state_next   = ADDR;
        end
      end

      ADDR: begin
        din_out     = addr_reg[2'd3 - bit_cnt[1:0]];
        frame_n_out = 1'b0;
        if (bit_cnt == 3'd3) begin
          bit_cnt_next = 3'd0;
          pad_cnt_next = 4'd0;
          state_next   = PAD;
        end else begin
          bit_cnt_next = bit_cnt + 3'd1;
        end
      end

      PAD: begin
        din_out     = 1'b1;
        frame_n_out = 1'b0;
        if (pad_cnt == PAD_LAST) begin
          pad_cnt_next = 4'd0;
          state_next   = WAIT;
        end else begin
          pad_cnt_next = pad_cnt + 4'd1;
        end
      end

      WAIT: begin
        din_out     = 1'b1;
        frame_n_out = 1'b0;
        byte_ready  = 1'b1;
        if (byte_valid) begin
          shift_next   = byte_data;
          last_next    = byte_last;
          bit_cnt_next = 3'd0;
          state_next   = DATA;
        end
      end

      DATA: begin
        din_out     = shift_reg[0];
        valid_n_out = 1'b0;
        frame_n_out = (bit_cnt == 3'd7) && last_reg;
        byte_ready  = (bit_cnt == 3'd7) && !last_reg;
        if (bit_cnt == 3'd7) begin
          bit_cnt_next = 3'd0;
          if (last_reg) begin
            shift_next = 8'd0;
            last_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (byte_valid) begin
            // Back-to-back byte: bit 0 of the new byte follows bit 7 with no gap.
            shift_next = byte_data;
            last_next  = byte_last;
          end else begin
            state_next = WAIT;
          end
        end else begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_reg  <= 4'd0;
      bit_cnt   <= 3'd0;
      pad_cnt   <= 4'd0;
      shift_reg <= 8'd0;
      last_reg  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= state_next;
      addr_reg  <= addr_next;
      bit_cnt   <= bit_cnt_next;
      pad_cnt   <= pad_cnt_next;
      shift_reg <= shift_next;
      last_reg  <= last_next;
      done_out  <= done_next;
    end
  end

endmodule

// File: doc/packet_tx.md
PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 Parameter: PAD_CYCLES, default 5, number of padding cycles between address and payload (legal 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset; one clock, no other clock domains.
REQ-004 start  input  1  request to begin a packet; sampled only in IDLE.
REQ-005 dest_addr  input  4  destination port, captured on the accepted start.
REQ-006 byte_valid  input  1  payload byte available from host.
REQ-007 byte_data  input  8  payload byte.
REQ-008 byte_last  input  1  marks byte_data as final byte of packet.
REQ-009 byte_ready  output  1  block accepts byte_data when byte_valid and byte_ready are both 1 at a rising edge.
REQ-010 din_out  output  1  serial line to router input port.
REQ-011 frame_n_out  output  1  active-low frame; low for entire packet except its final bit.
REQ-012 valid_n_out  output  1  active-low, low only while a payload bit is on din_out.
REQ-013 busy_out  output  1  high whenever state is not IDLE.
REQ-014 done_out  output  1  one-cycle pulse after packet completes.

Function
REQ-015 States SHALL be IDLE, ADDR, PAD, WAIT, DATA; all outputs SHALL be registered-state decoded (no combinational path from inputs to din_out/frame_n_out/valid_n_out).
REQ-016 IDLE: frame_n_out=1, valid_n_out=1, din_out=0, byte_ready=0; start=1 at an edge captures dest_addr and moves to ADDR; start outside IDLE SHALL be ignored.
REQ-017 ADDR: 4 cycles, din_out = dest_addr[3], [2], [1], [0] in order (MSB first), frame_n_out=0, valid_n_out=1; first address bit appears in the first cycle frame_n_out is low.
REQ-018 PAD: exactly PAD_CYCLES cycles, din_out=1, frame_n_out=0, valid_n_out=1, then WAIT.
REQ-019 WAIT: din_out=1, frame_n_out=0, valid_n_out=1, byte_ready=1; byte handshake loads an 8-bit shift register and last flag, next state DATA; stays in WAIT indefinitely otherwise.
REQ-020 DATA: 8 cycles, din_out = byte bit 0..7 (LSB first), valid_n_out=0, frame_n_out=0 except frame_n_out=1 during bit 7 of the last byte.
REQ-021 During bit 7 of a non-last byte, byte_ready=1; handshake there gives back-to-back next byte (bit 0 next cycle, no gap); no handshake goes to WAIT (valid_n_out high for gap cycles).
REQ-022 byte_ready SHALL be 0 in DATA bits 0..6 and during bit 7 of the last byte.
REQ-023 After bit 7 of the last byte, next state SHALL be IDLE with done_out=1 for that single first IDLE cycle; start in that same cycle SHALL be accepted.
REQ-024 Bit counter 3 bits, pad counter 4 bits; both SHALL wrap only via state change, never mid-state.
REQ-025 Minimum packet (1 byte): 4 + PAD_CYCLES + 1 (WAIT) + 8 cycles of frame_n_out activity; frame_n_out low for all but the last.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force IDLE, frame_n_out=1, valid_n_out=1, din_out=0, byte_ready=0, busy_out=0, done_out=0, counters and shift register 0.
REQ-027 reset asserted mid-packet SHALL abort the packet with no done_out pulse; first start after release begins a fresh packet.

Verification
REQ-028 start with dest_addr=4'b1010, PAD_CYCLES=5, one byte 8'hA5 last=1 ready in WAIT -> din_out 1,0,1,0, five 1s, one WAIT cycle, then 1,0,1,0,0,1,0,1; frame_n_out low 17 cycles, high on final bit; done_out pulses once.
REQ-029 Two bytes 8'h01, 8'hFF(last) valid at bit 7 of first -> 16 consecutive valid_n_out=0 cycles, no gap, frame_n_out=1 only on 16th.
REQ-030 Second byte withheld 3 cycles after first byte's bit 7 -> 3 cycles valid_n_out=1, frame_n_out=0, din_out=1, byte_ready=1, then payload resumes.
REQ-031 reset pulse during PAD -> outputs to idle values same cycle, done_out never asserts; new start with dest_addr=4'hF sends 1,1,1,1.
REQ-032 start held high through an entire packet and at done cycle -> exactly one packet per IDLE entry, next packet starts the cycle after done_out.
